ser_seq_ctrl: RTL and testbench

// - Multi-beat sequencer for the serialized RV32 datapath, generalising the half-word split to NSLICE = XLEN/SLICE_W slices.
// - Accepts one decoded instruction per handshake, then steps beat index, slice direction and phase (EXEC/MEM/WB).
// - Drives RF write strobes, LSU request and branch evaluation until the instruction retires.
// - Sits between fetch/decode and the slice ALU/LSU. ALU op selection stays in the combinational decoder.

---
 rtl/ser_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_ser_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_seq_ctrl.sv
// ser_seq_ctrl: multi-beat sequencer for the serialized RV32 datapath.
// Takes one decoded instruction per handshake and walks it through the
// EXEC / MEM / WB phases one slice per cycle (NSLICE = XLEN / SLICE_W slices).
// While doing so it produces the beat index, the slice order, the RF write
// strobe, the LSU request and the branch-evaluate pulse.
// ALU operation selection is not done here; it stays in the combinational decoder.
// Optional feature macro: SER_BRANCH_EARLY_EXIT_EN. When it is defined, BEQ/BNE
// retire at the first slice that compares unequal.
module ser_seq_ctrl #(
    parameter int  XLEN    = 32,
    parameter int  SLICE_W = 16,
    localparam int BEAT_W  = ((XLEN / SLICE_W) > 1) ? $clog2(XLEN / SLICE_W) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid_i,
    output logic              inst_ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic              funct7_b5_i,
    input  logic              stall_i,
    input  logic              eq_slice_i,
    input  logic              dmem_ack_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [BEAT_W-1:0] beat_o,
    output logic              slice_desc_o,
    output logic              first_beat_o,
    output logic              last_beat_o,
    output logic              rf_we_o,
    output logic              branch_eval_o,
    output logic              cmp_flip_o,
    output logic              done_o,
    output logic              illegal_o
);

    localparam int NSLICE = XLEN / SLICE_W;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NSLICE - 1);

    if (((XLEN % SLICE_W) != 0) || (NSLICE < 2)) begin : g_param_check
        $error("ser_seq_ctrl: XLEN must be a multiple of SLICE_W with at least two slices");
    end

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MEM  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    // Sequencing class of an instruction; K_WR is the reset value of the latch.
    typedef enum logic [2:0] {
        K_WR  = 3'd0,  // writes rd every EXEC beat (LUI/AUIPC/JAL/JALR/ALU)
        K_SLT = 3'd1,  // compare across all slices, then write in WB
        K_BR  = 3'd2,  // conditional branch
        K_LD  = 3'd3,  // load: address beats, MEM, WB
        K_ST  = 3'd4,  // store: address beats, MEM
        K_ILL = 3'd5   // unsupported encoding
    } kind_t;

    state_t            state;
    state_t            state_nxt;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] beat_nxt;
    kind_t             kind;
    logic              desc;
    logic              flip;

    kind_t             dec_kind;
    logic              dec_desc;
    logic              accept;
    logic [BEAT_W-1:0] beat_start;
    logic [BEAT_W-1:0] beat_end;
    logic              exec_last;
    logic              early_exit;

    // Classify the incoming instruction and choose its EXEC slice order.
    always_comb begin
        dec_kind = K_ILL;
        dec_desc = 1'b0;
        case (opcode_i)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
                dec_kind = K_WR;
            end
            OPC_OP, OPC_OP_IMM: begin
                if ((funct3_i == 3'b010) || (funct3_i == 3'b011)) begin
                    // SLT/SLTU: the sign and magnitude are decided from the top slice down
                    dec_kind = K_SLT;
                    dec_desc = 1'b1;
                end else begin
                    // Right shifts need the upper slice first so that bits can move downward
                    dec_kind = K_WR;
                    dec_desc = (funct3_i == 3'b101);
                end
            end
            OPC_BRANCH: begin
                if (funct3_i[2:1] != 2'b01) begin
                    dec_kind = K_BR;
                    dec_desc = funct3_i[2];
                end
            end
            OPC_LOAD:  dec_kind = K_LD;
            OPC_STORE: dec_kind = K_ST;
            default:   dec_kind = K_ILL;
        endcase
    end

    assign accept     = inst_valid_i && (state == S_IDLE);
    assign beat_start = desc ? BEAT_LAST : '0;
    assign beat_end   = desc ? '0 : BEAT_LAST;
    assign exec_last  = (beat == beat_end);

`ifdef SER_BRANCH_EARLY_EXIT_EN
    logic is_eqne;
    logic unused_inputs;

    assign unused_inputs = funct7_b5_i;

    // Remember whether the accepted branch is BEQ/BNE (the only ones that can exit early).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_eqne <= 1'b0;
        end else if (accept) begin
            is_eqne <= (dec_kind == K_BR) && (funct3_i[2:1] == 2'b00);
        end
    end

    assign early_exit = (state == S_EXEC) && (kind == K_BR) && is_eqne &&
                        !stall_i && !eq_slice_i && !exec_last;
`else
    logic unused_inputs;

    // Shift direction (SRA vs SRL) does not affect the sequencing, and the slice-equality
    // flag only matters when early exit is enabled.
    assign unused_inputs = ^{funct7_b5_i, eq_slice_i};
    assign early_exit    = 1'b0;
`endif

    // Phase state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Beat counter, plus the per-instruction fields captured on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat <= '0;
            kind <= K_WR;
            desc <= 1'b0;
            flip <= 1'b0;
        end else begin
            beat <= beat_nxt;
            if (accept) begin
                kind <= dec_kind;
                desc <= dec_desc;
                flip <= (dec_kind == K_BR) && funct3_i[0];
            end
        end
    end

    // Next phase and beat; every path back to IDLE parks the beat at 0.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        unique case (state)
            S_IDLE: begin
                if (inst_valid_i) begin
                    state_nxt = S_EXEC;
                    beat_nxt  = dec_desc ? BEAT_LAST : '0;
                end
            end
            S_EXEC: begin
                if (!stall_i) begin
                    if ((kind == K_ILL) || early_exit) begin
                        state_nxt = S_IDLE;
                        beat_nxt  = '0;
                    end else if (exec_last) begin
                        beat_nxt = '0;
                        case (kind)
                            K_SLT:      state_nxt = S_WB;
                            K_LD, K_ST: state_nxt = S_MEM;
                            default:    state_nxt = S_IDLE;
                        endcase
                    end else begin
                        beat_nxt = desc ? (beat - BEAT_W'(1)) : (beat + BEAT_W'(1));
                    end
                end
            end
            S_MEM: begin
                // A stall is ignored here: the acknowledge always completes the request.
                if (dmem_ack_i) begin
                    state_nxt = (kind == K_ST) ? S_IDLE : S_WB;
                    beat_nxt  = '0;
                end
            end
            S_WB: begin
                if (!stall_i) begin
                    if (beat == BEAT_LAST) begin
                        state_nxt = S_IDLE;
                        beat_nxt  = '0;
                    end else begin
                        beat_nxt = beat + BEAT_W'(1);
                    end
                end
            end
        endcase
    end

    // Output decode; a stall masks only the strobes, not the beat or the phase flags.
    always_comb begin
        inst_ready_o  = 1'b0;
        dmem_req_o    = 1'b0;
        dmem_we_o     = 1'b0;
        beat_o        = beat;
        slice_desc_o  = 1'b0;
        first_beat_o  = 1'b0;
        last_beat_o   = 1'b0;
        rf_we_o       = 1'b0;
        branch_eval_o = 1'b0;
        cmp_flip_o    = 1'b0;
        done_o        = 1'b0;
        illegal_o     = 1'b0;
        unique case (state)
            S_IDLE: begin
                inst_ready_o = 1'b1;
            end
            S_EXEC: begin
                slice_desc_o = desc;
                cmp_flip_o   = (kind == K_BR) && flip;
                if (kind == K_ILL) begin
                    done_o    = !stall_i;
                    illegal_o = !stall_i;
                end else begin
                    first_beat_o  = (beat == beat_start);
                    last_beat_o   = exec_last;
                    rf_we_o       = !stall_i && (kind == K_WR);
                    branch_eval_o = (kind == K_BR) && !stall_i && (exec_last || early_exit);
                    done_o        = !stall_i &&
                                    ((exec_last && ((kind == K_WR) || (kind == K_BR))) || early_exit);
                end
            end
            S_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = (kind == K_ST);
                done_o     = dmem_ack_i && (kind == K_ST);
            end
            S_WB: begin
                first_beat_o = (beat == '0);
                last_beat_o  = (beat == BEAT_LAST);
                rf_we_o      = !stall_i;
                done_o       = !stall_i && (beat == BEAT_LAST);
            end
        endcase
    end

endmodule

// File: tb/tb_ser_seq_ctrl.sv
// Testbench for ser_seq_ctrl: drives a two-slice instance (SLICE_W=16) and a
// four-slice instance (SLICE_W=8).
// For each accepted instruction, the expected output trace is built as a queue
// of beat slots, derived from the instruction class.
module tb_ser_seq_ctrl;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] PH_EXEC = 2'd0;
    localparam logic [1:0] PH_MEM  = 2'd1;
    localparam logic [1:0] PH_WB   = 2'd2;

    // Observed/expected word: {ready, req, dwe, desc, first, last, we, br, flip, done, ill, beat[1:0]}
    localparam logic [12:0] IDLE_WORD = 13'h1000;

`ifdef SER_BRANCH_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] ph;
        logic [1:0] beat;
        logic       first;
        logic       last;
        logic       we;
        logic       br;
        logic       done;
        logic       ill;
        logic       eqne;
    } slot_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0]      inst_valid, f7b5, stall, eq_slice, dmem_ack;
    logic [1:0][6:0] opcode;
    logic [1:0][2:0] funct3;
    logic [1:0]      ready, req, dwe, desc, first, last, we, br, flip, done, ill;
    logic [0:0]      beat0;
    logic [1:0]      beat1;

    int n_cmp;
    int n_fail;
    int lat;

    always #5 clk = ~clk;

    ser_seq_ctrl #(.XLEN(32), .SLICE_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .inst_valid_i(inst_valid[0]), .inst_ready_o(ready[0]),
        .opcode_i(opcode[0]), .funct3_i(funct3[0]), .funct7_b5_i(f7b5[0]),
        .stall_i(stall[0]), .eq_slice_i(eq_slice[0]), .dmem_ack_i(dmem_ack[0]),
        .dmem_req_o(req[0]), .dmem_we_o(dwe[0]), .beat_o(beat0),
        .slice_desc_o(desc[0]), .first_beat_o(first[0]), .last_beat_o(last[0]),
        .rf_we_o(we[0]), .branch_eval_o(br[0]), .cmp_flip_o(flip[0]),
        .done_o(done[0]), .illegal_o(ill[0])
    );

    ser_seq_ctrl #(.XLEN(32), .SLICE_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .inst_valid_i(inst_valid[1]), .inst_ready_o(ready[1]),
        .opcode_i(opcode[1]), .funct3_i(funct3[1]), .funct7_b5_i(f7b5[1]),
        .stall_i(stall[1]), .eq_slice_i(eq_slice[1]), .dmem_ack_i(dmem_ack[1]),
        .dmem_req_o(req[1]), .dmem_we_o(dwe[1]), .beat_o(beat1),
        .slice_desc_o(desc[1]), .first_beat_o(first[1]), .last_beat_o(last[1]),
        .rf_we_o(we[1]), .branch_eval_o(br[1]), .cmp_flip_o(flip[1]),
        .done_o(done[1]), .illegal_o(ill[1])
    );

    function automatic logic [12:0] obs(input int d);
        logic [1:0] b;
        b = (d == 0) ? {1'b0, beat0} : beat1;
        return {ready[d], req[d], dwe[d], desc[d], first[d], last[d], we[d], br[d],
                flip[d], done[d], ill[d], b};
    endfunction

    function automatic slot_t mk_slot(input logic [1:0] ph, input int beat, input logic fst,
                                      input logic lst, input logic w, input logic b,
                                      input logic dn, input logic il, input logic eqne);
        slot_t s;
        s.ph = ph; s.beat = 2'(beat); s.first = fst; s.last = lst; s.we = w;
        s.br = b; s.done = dn; s.ill = il; s.eqne = eqne;
        return s;
    endfunction

    task automatic check_now(input int d, input logic [12:0] expv, input string tag);
        logic [12:0] o;
        o = obs(d);
        n_cmp++;
        assert (o === expv) else begin
            n_fail++;
            $error("FAIL %s dut%0d t=%0t: observed %h expected %h", tag, d, $time, o, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    // Inputs are driven at posedge+1; outputs are checked on the falling edge.
    task automatic step_check(input int d, input logic [12:0] expv, input string tag);
        @(negedge clk);
        check_now(d, expv, tag);
        @(posedge clk);
        #1;
    endtask

    // stall_mode: 0 none, 1 random, 2 only on the first busy cycle.
    // ack_wait: number of MEM cycles without ack (-1 = random).
    // eq_mode: 0 random, 1 unequal on the first busy cycle only.
    task automatic run_inst(input int d, input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input int stall_mode, input int ack_wait,
                            input int eq_mode, output int busy);
        slot_t q[$];
        slot_t s;
        int n, mem_cnt, st_run;
        logic is_br, alu, slt, writer, is_mem, store, legal, m_desc, m_flip;
        logic st, a, e, early, ex_d, ex_f;
        logic [12:0] expv;

        n      = (d == 0) ? 2 : 4;
        is_br  = (op == OPC_BRANCH);
        alu    = (op == OPC_OP) || (op == OPC_OP_IMM);
        slt    = alu && ((f3 == 3'd2) || (f3 == 3'd3));
        writer = (op == OPC_LUI) || (op == OPC_AUIPC) || (op == OPC_JAL) ||
                 (op == OPC_JALR) || (alu && !slt);
        is_mem = (op == OPC_LOAD) || (op == OPC_STORE);
        store  = (op == OPC_STORE);
        legal  = (writer || alu || is_mem || is_br) && !(is_br && ((f3 == 3'd2) || (f3 == 3'd3)));
        m_desc = legal && ((alu && ((f3 == 3'd5) || slt)) || (is_br && f3[2]));
        m_flip = legal && is_br && f3[0];

        if (!legal) begin
            q.push_back(mk_slot(PH_EXEC, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        end else begin
            for (int k = 0; k < n; k++) begin
                q.push_back(mk_slot(PH_EXEC, m_desc ? (n - 1 - k) : k, k == 0, k == n - 1,
                                    writer, is_br && (k == n - 1),
                                    (writer || is_br) && (k == n - 1), 1'b0,
                                    is_br && (f3[2:1] == 2'b00)));
            end
            if (is_mem) begin
                q.push_back(mk_slot(PH_MEM, 0, 1'b0, 1'b0, 1'b0, 1'b0, store, 1'b0, 1'b0));
            end
            if (slt || (is_mem && !store)) begin
                for (int k = 0; k < n; k++) begin
                    q.push_back(mk_slot(PH_WB, k, k == 0, k == n - 1, 1'b1, 1'b0,
                                        k == n - 1, 1'b0, 1'b0));
                end
            end
        end

        inst_valid[d] = 1'b1; opcode[d] = op; funct3[d] = f3; f7b5[d] = f7;
        stall[d] = 1'b0; eq_slice[d] = 1'b1; dmem_ack[d] = 1'b0;
        step_check(d, IDLE_WORD, "accept");

        busy = 0; mem_cnt = 0; st_run = 0;
        while (q.size() > 0) begin
            s = q[0];
            // Unrelated instructions presented while busy must be ignored.
            inst_valid[d] = 1'($urandom_range(0, 1));
            opcode[d]     = 7'($urandom);
            funct3[d]     = 3'($urandom);
            case (stall_mode)
                0:       st = 1'b0;
                1:       st = (st_run < 2) && ($urandom_range(0, 2) == 0);
                default: st = (busy == 0);
            endcase
            st_run = st ? st_run + 1 : 0;
            e = (eq_mode == 1) ? (busy != 0) : 1'($urandom_range(0, 1));
            if (s.ph == PH_MEM)
                a = (ack_wait >= 0) ? (mem_cnt == ack_wait)
                                    : ((mem_cnt >= 6) || ($urandom_range(0, 2) == 0));
            else
                a = 1'b0;
            stall[d] = st; eq_slice[d] = e; dmem_ack[d] = a;

            ex_d = (s.ph == PH_EXEC) && m_desc;
            ex_f = (s.ph == PH_EXEC) && m_flip;
            early = 1'b0;
            if (s.ph == PH_MEM) begin
                expv = {1'b0, 1'b1, store, 6'b0, a && store, 1'b0, 2'b00};
                mem_cnt++;
                if (a) void'(q.pop_front());
            end else if (st) begin
                expv = {3'b000, ex_d, s.first, s.last, 2'b00, ex_f, 2'b00, s.beat};
            end else begin
                early = EARLY && s.eqne && !s.last && !e;
                expv = {3'b000, ex_d, s.first, s.last, s.we, s.br || early, ex_f,
                        s.done || early, s.ill, s.beat};
                if (early) q.delete();
                else void'(q.pop_front());
            end
            step_check(d, expv, "busy");
            busy++;
        end
        inst_valid[d] = 1'b0; stall[d] = 1'b0; dmem_ack[d] = 1'b0; eq_slice[d] = 1'b1;
    endtask

    function automatic logic [6:0] pick_op(input int i);
        case (i)
            0:       return OPC_OP;
            1:       return OPC_OP_IMM;
            2:       return OPC_BRANCH;
            3:       return OPC_BRANCH;
            4:       return OPC_LOAD;
            5:       return OPC_STORE;
            6:       return OPC_LUI;
            7:       return OPC_AUIPC;
            8:       return OPC_JAL;
            9:       return OPC_JALR;
            10:      return 7'h7F;
            default: return 7'b0001111;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0;
        inst_valid = '0; f7b5 = '0; stall = '0; eq_slice = '1; dmem_ack = '0;
        opcode = '0; funct3 = '0;
        #2;
        check_now(0, IDLE_WORD, "reset");
        check_now(1, IDLE_WORD, "reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD on two slices: beats 0,1 with writes, done on the second beat.
        run_inst(0, OPC_OP, 3'd0, 1'b0, 0, -1, 0, lat);
        chk_int("add_latency", lat, 2);
        // SRA on four slices: beats 3,2,1,0 descending, with writes.
        run_inst(1, OPC_OP, 3'd5, 1'b1, 0, -1, 0, lat);
        chk_int("sra_latency", lat, 4);
        // LW: two address beats, request held three cycles, two WB beats.
        run_inst(0, OPC_LOAD, 3'd2, 1'b0, 0, 2, 0, lat);
        chk_int("lw_latency", lat, 7);
        // SLTU with a stall on the first EXEC cycle.
        run_inst(0, OPC_OP, 3'd3, 1'b0, 2, -1, 0, lat);
        chk_int("sltu_latency", lat, 5);
        // BEQ with the first slice unequal.
        run_inst(0, OPC_BRANCH, 3'd0, 1'b0, 0, -1, 1, lat);
        chk_int("beq_latency", lat, EARLY ? 1 : 2);
        // Unsupported opcode retires at once, flagged illegal.
        run_inst(0, 7'h7F, 3'd0, 1'b0, 0, -1, 0, lat);
        chk_int("illegal_latency", lat, 1);

        // Reset asserted while a load waits in MEM.
        inst_valid[0] = 1'b1; opcode[0] = OPC_LOAD; funct3[0] = 3'd2;
        step_check(0, IDLE_WORD, "rst_accept");
        inst_valid[0] = 1'b0;
        step_check(0, 13'h0100, "rst_exec0");
        step_check(0, 13'h0081, "rst_exec1");
        step_check(0, 13'h0800, "rst_mem");
        #2 rst_n = 1'b0;
        #1 check_now(0, IDLE_WORD, "rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step_check(0, IDLE_WORD, "rst_idle");

        // Random mix on both instances with random stalls, acks and slice compares.
        for (int i = 0; i < 60; i++) begin
            logic [6:0] op;
            logic [2:0] f3;
            op = pick_op($urandom_range(0, 11));
            f3 = 3'($urandom);
            run_inst(i % 2, op, f3, 1'($urandom), 1, -1, 0, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
